// File: rtl/soc_reset_pkg.sv
// Shared encodings and helpers for the SoC reset sequencer.
package soc_reset_pkg;

  localparam logic [1:0] RESET     = 2'd0;
  localparam logic [1:0] WAIT_LOCK = 2'd1;
  localparam logic [1:0] HOLD      = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  typedef enum logic [1:0] {
    StReset    = RESET,
    StWaitLock = WAIT_LOCK,
    StHold     = HOLD,
    StRun      = RUN
  } seq_state_e;

  localparam int unsigned LOST_CNT_W = 8;

  // Bits needed for a counter that must reach max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/soc_reset_sequencer_debounce.sv
// Synchronizes the active-low user button and debounces it into btn_db_o (1 = pressed).
module reset_debounce
  import soc_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic button_n_i,
  output logic btn_db_o
);

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_q, db_d;

  always_ff @(posedge clk_i) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], button_n_i};
  end

  assign btn_s = ~sync_q[SYNC_STAGES-1];

  // Counter only runs while the raw sample disagrees with the debounced value.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (btn_s != db_q) begin
      if (cnt_q == DbLast) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign btn_db_o = db_q;

endmodule

// File: rtl/soc_reset_sequencer.sv
// Qualifies PLL lock and the user button, then releases soc_reset and, later,
// periph_reset in a counted order.
module soc_reset_sequencer
  import soc_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE     = 1024,
  parameter int unsigned SOC_HOLD        = 64,
  parameter int unsigned PERIPH_DELAY    = 256,
  parameter int unsigned CNT_W           = 20
) (
  input  logic                  io_systemClk,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  button_n,
  output logic                  soc_reset,
  output logic                  periph_reset,
  output logic [1:0]            seq_state,
  output logic [LOST_CNT_W-1:0] lock_lost_count
);

  localparam logic [CNT_W-1:0] LockLast    = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(SOC_HOLD - 1);
  localparam logic [CNT_W-1:0] PeriphDelay = CNT_W'(PERIPH_DELAY);

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_s;
  logic                   btn_db;
  logic                   abort;

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  soc_reset_q, soc_reset_d;
  logic                  periph_reset_q, periph_reset_d;
  logic [LOST_CNT_W-1:0] lost_q, lost_d;

  always_ff @(posedge io_systemClk) begin
    lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  reset_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk_i     (io_systemClk),
    .reset_i   (reset),
    .button_n_i(button_n),
    .btn_db_o  (btn_db)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    abort   = (state_q != StReset) && (!lock_s || btn_db);

    case (state_q)
      StReset: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
      StWaitLock: begin
        if (cnt_q == LockLast) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRun: begin
        if (cnt_q < PeriphDelay) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StReset;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides any counter completion in the same cycle.
    if (abort) begin
      state_d = StWaitLock;
      cnt_d   = '0;
      if ((state_q == StRun) && !lock_s && (lost_q != '1)) begin
        lost_d = lost_q + LOST_CNT_W'(1);
      end
    end

    // Release needs one settled cycle in RUN; any exit re-asserts immediately.
    soc_reset_d    = !((state_q == StRun) && (state_d == StRun));
    periph_reset_d = soc_reset_d || (cnt_q < PeriphDelay);
  end

  always_ff @(posedge io_systemClk) begin
    if (reset) begin
      state_q        <= StReset;
      cnt_q          <= '0;
      soc_reset_q    <= 1'b1;
      periph_reset_q <= 1'b1;
      lost_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      soc_reset_q    <= soc_reset_d;
      periph_reset_q <= periph_reset_d;
      lost_q         <= lost_d;
    end
  end

  assign soc_reset       = soc_reset_q;
  assign periph_reset    = periph_reset_q;
  assign seq_state       = state_q;
  assign lock_lost_count = lost_q;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Scenario bench for soc_reset_sequencer: expectations are queued per cycle and
// compared by an independent monitor on the falling edge.
module tb_soc_reset_sequencer;

  localparam int SigSoc    = 0;
  localparam int SigPeriph = 1;
  localparam int SigState  = 2;
  localparam int SigLost   = 3;
  localparam int SigBtn    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b1;
  logic       button_n = 1'b1;
  logic       soc_reset;
  logic       periph_reset;
  logic [1:0] seq_state;
  logic [7:0] lock_lost_count;

  soc_reset_sequencer #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(5),
    .LOCK_STABLE    (8),
    .SOC_HOLD       (4),
    .PERIPH_DELAY   (6),
    .CNT_W          (20)
  ) dut (
    .io_systemClk   (clk),
    .reset          (reset),
    .pll_locked     (pll_locked),
    .button_n       (button_n),
    .soc_reset      (soc_reset),
    .periph_reset   (periph_reset),
    .seq_state      (seq_state),
    .lock_lost_count(lock_lost_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t keep[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   base = 0;
  bit   flush = 1'b0;

  function automatic int actual(input int sig);
    case (sig)
      SigSoc:    return int'(soc_reset);
      SigPeriph: return int'(periph_reset);
      SigState:  return int'(seq_state);
      SigLost:   return int'(lock_lost_count);
      default:   return int'(dut.btn_db);
    endcase
  endfunction

  task automatic expect_at(input int rel, input int sig, input int val, input string name);
    exp_t e;
    e.cyc  = base + rel;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: pops every entry due this cycle; stale entries count as failures.
  always @(negedge clk) begin
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        n_checks++;
        if (actual(sb[i].sig) != sb[i].val) begin
          n_errors++;
          $display("FAIL %s @cycle %0d: got %0d want %0d", sb[i].name, cyc,
                   actual(sb[i].sig), sb[i].val);
        end
      end else if (flush || (sb[i].cyc < cyc)) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: due cycle %0d, never sampled (now %0d)", sb[i].name, sb[i].cyc, cyc);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic goto(input int rel);
    while (cyc < base + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Relative cycle 0 is the first edge that samples reset low.
  task automatic do_reset();
    reset      = 1'b1;
    pll_locked = 1'b1;
    button_n   = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    base  = cyc + 1;
    expect_at(-1, SigState, 0, "rst_state");
    expect_at(-1, SigSoc, 1, "rst_soc");
    expect_at(-1, SigPeriph, 1, "rst_periph");
    expect_at(-1, SigLost, 0, "rst_lost");
  endtask

  initial begin
    // Nominal bring-up.
    do_reset();
    expect_at(0, SigState, 1, "nom_wait");
    expect_at(7, SigState, 1, "nom_wait_end");
    expect_at(8, SigState, 2, "nom_hold");
    expect_at(11, SigState, 2, "nom_hold_end");
    expect_at(12, SigState, 3, "nom_run");
    expect_at(12, SigSoc, 1, "nom_soc_pre");
    expect_at(13, SigSoc, 0, "nom_soc_rel");
    expect_at(13, SigPeriph, 1, "nom_periph_held");
    expect_at(18, SigPeriph, 1, "nom_periph_pre");
    expect_at(19, SigPeriph, 0, "nom_periph_rel");
    expect_at(25, SigLost, 0, "nom_lost");
    goto(26);

    // Lock drop in RUN for 3 cycles.
    base       = cyc + 1;
    pll_locked = 1'b0;
    expect_at(1, SigState, 3, "drop_still_run");
    expect_at(1, SigSoc, 0, "drop_soc_pre");
    expect_at(2, SigState, 1, "drop_wait");
    expect_at(2, SigSoc, 1, "drop_soc");
    expect_at(2, SigPeriph, 1, "drop_periph");
    expect_at(2, SigLost, 1, "drop_lost");
    expect_at(15, SigState, 2, "drop_hold");
    expect_at(16, SigState, 3, "drop_run");
    expect_at(16, SigSoc, 1, "drop_soc_pre_rel");
    expect_at(17, SigSoc, 0, "drop_soc_rel");
    expect_at(22, SigPeriph, 1, "drop_periph_pre");
    expect_at(23, SigPeriph, 0, "drop_periph_rel");
    expect_at(23, SigLost, 1, "drop_lost_hold");
    goto(2);
    pll_locked = 1'b1;
    goto(24);

    // Two 3-cycle press pulses are filtered.
    base     = cyc + 1;
    button_n = 1'b0;
    expect_at(4, SigBtn, 0, "bounce_db1");
    expect_at(10, SigBtn, 0, "bounce_db2");
    expect_at(14, SigBtn, 0, "bounce_db3");
    expect_at(14, SigState, 3, "bounce_state");
    expect_at(14, SigSoc, 0, "bounce_soc");
    expect_at(14, SigPeriph, 0, "bounce_periph");
    goto(2);
    button_n = 1'b1;
    goto(5);
    button_n = 1'b0;
    goto(8);
    button_n = 1'b1;
    goto(15);

    // 10-cycle press aborts, release restarts the sequence.
    base     = cyc + 1;
    button_n = 1'b0;
    expect_at(5, SigBtn, 0, "press_db_pre");
    expect_at(6, SigBtn, 1, "press_db");
    expect_at(6, SigState, 3, "press_still_run");
    expect_at(6, SigSoc, 0, "press_soc_pre");
    expect_at(7, SigState, 1, "press_wait");
    expect_at(7, SigSoc, 1, "press_soc");
    expect_at(7, SigPeriph, 1, "press_periph");
    expect_at(7, SigLost, 1, "press_lost");
    expect_at(15, SigBtn, 1, "rel_db_pre");
    expect_at(16, SigBtn, 0, "rel_db");
    expect_at(16, SigState, 1, "rel_wait");
    expect_at(27, SigState, 2, "rel_hold");
    expect_at(28, SigState, 3, "rel_run");
    expect_at(28, SigSoc, 1, "rel_soc_pre");
    expect_at(29, SigSoc, 0, "rel_soc");
    expect_at(29, SigLost, 1, "rel_lost");
    goto(9);
    button_n = 1'b1;
    goto(30);

    // Lock loss coincident with HOLD completion.
    do_reset();
    expect_at(11, SigState, 2, "habort_hold");
    expect_at(12, SigState, 1, "habort_wait");
    expect_at(12, SigSoc, 1, "habort_soc12");
    expect_at(14, SigSoc, 1, "habort_soc14");
    expect_at(20, SigState, 1, "habort_state20");
    expect_at(20, SigSoc, 1, "habort_soc20");
    expect_at(20, SigLost, 0, "habort_lost");
    goto(9);
    pll_locked = 1'b0;
    goto(21);
    pll_locked = 1'b1;

    // 300 lock drops in RUN saturate the loss counter.
    do_reset();
    expect_at(20, SigState, 3, "sat_run");
    expect_at(20, SigSoc, 0, "sat_soc");
    goto(21);
    for (int i = 0; i < 300; i++) begin
      base       = cyc + 1;
      pll_locked = 1'b0;
      expect_at(2, SigLost, (i + 1 > 255) ? 255 : i + 1, "sat_lost");
      expect_at(2, SigState, 1, "sat_wait");
      goto(2);
      pll_locked = 1'b1;
      goto(21);
    end

    // Reset pulse during RUN.
    base = cyc + 1;
    expect_at(-1, SigLost, 255, "mid_lost_pre");
    expect_at(-1, SigSoc, 0, "mid_soc_pre");
    expect_at(-1, SigState, 3, "mid_state_pre");
    expect_at(0, SigState, 0, "mid_state");
    expect_at(0, SigSoc, 1, "mid_soc");
    expect_at(0, SigPeriph, 1, "mid_periph");
    expect_at(0, SigLost, 0, "mid_lost");
    expect_at(1, SigState, 1, "mid_restart");
    reset = 1'b1;
    goto(0);
    reset = 1'b0;
    goto(3);

    for (int i = 0; i < 5 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
